dispatch4way: RTL

DISPATCH4WAY -- requirements
Module: dispatch4way

---
 rtl/dispatch4way.sv | 68 ++++++
 1 files changed

// File: rtl/dispatch4way.sv
// Four-lane input dispatcher: each accepted word is steered to one output lane register,
// chosen either by sel (directed) or by an internal round-robin pointer.
module dispatch4way #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic [1:0]   sel,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [7:0]   acc_cnt,
    output logic [1:0]   rr_ptr
);

    logic [1:0]   target;
    logic [3:0]   drain;
    logic         accept;
    logic [W-1:0] laneData [4];

    // A full target lane can still take a word if its consumer empties it this cycle.
    always_comb begin
        target   = mode ? rr_ptr : sel;
        drain    = out_valid & out_ready;
        in_ready = !rst && (!out_valid[target] || drain[target]);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                laneData[k] <= '0;
            end
            out_valid <= '0;
            acc_cnt   <= '0;
            rr_ptr    <= '0;
        end else begin
            // A reload wins over a drain on the same lane so the lane stays occupied.
            for (int k = 0; k < 4; k++) begin
                if (accept && (target == 2'(k))) begin
                    laneData[k]  <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (drain[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                acc_cnt <= acc_cnt + 8'd1;
                if (mode) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

    assign out_data0 = laneData[0];
    assign out_data1 = laneData[1];
    assign out_data2 = laneData[2];
    assign out_data3 = laneData[3];

endmodule
